seq_adder: RTL and testbench
============================

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter SLICE, default 1, meaning bits added per clock; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to begin an operation.
REQ-006 The block SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-007 The block SHALL have port x  input  WIDTH  first operand, unsigned or two's-complement.
REQ-008 The block SHALL have port y  input  WIDTH  second operand.
REQ-009 The block SHALL have port cin  input  1  carry-in, used in add mode only.
REQ-010 The block SHALL have port s  output  WIDTH  registered result.
REQ-011 The block SHALL have port c  output  1  registered carry-out of the MSB; in subtract mode 1 means no borrow.
REQ-012 The block SHALL have port ovf  output  1  registered signed overflow flag.
REQ-013 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse marking a valid new result.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at a rising edge (E0) SHALL latch x, y, sub and cin into internal registers, clear the slice counter, enter RUN and set busy=1.
REQ-017 In RUN, start SHALL be ignored, and changes on x, y, sub or cin SHALL NOT affect the operation in progress.
REQ-018 In RUN, each rising edge SHALL add one SLICE-bit slice, LSB slice first, from the latched operands plus the registered carry from the previous slice.
REQ-019 The effective operands SHALL be: add mode, y_eff=y and carry-in=cin; subtract mode, y_eff=~y and carry-in=1, with cin ignored.
REQ-020 N=WIDTH/SLICE; the final slice SHALL be processed at edge EN=E0+N, at which s, c and ovf update together, busy goes to 0, done goes to 1 and the FSM enters DONE.
REQ-021 s, c and ovf SHALL hold their previous values from E0 until EN; partial sums SHALL NOT be visible on s.
REQ-022 At EN: s SHALL equal (x + y_eff + carry-in) mod 2^WIDTH, and c SHALL equal bit WIDTH of that full sum.
REQ-023 At EN: ovf SHALL equal (x[MSB]==y_eff[MSB]) AND (s[MSB]!=x[MSB]).
REQ-024 DONE SHALL last exactly one cycle; at the next edge the FSM SHALL go to RUN if start=1 (back-to-back operation, done then returns to 0), otherwise to IDLE.
REQ-025 done SHALL be 1 only in DONE, and busy SHALL be 1 only in RUN; busy and done SHALL never both be 1.
REQ-026 Results SHALL remain stable after DONE until the next completion, or until reset.
REQ-027 Carry SHALL wrap out of the MSB into c only; no result bit beyond WIDTH SHALL exist.

Reset
REQ-028 Asserting rst SHALL immediately, without a clock, force state IDLE and s=0, c=0, ovf=0, busy=0, done=0, and clear the slice counter and internal carry.
REQ-029 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-030 While rst=1, start SHALL be ignored.
REQ-031 After rst deasserts, the first start accepted SHALL behave exactly per REQ-016.

Verification
REQ-032 With WIDTH=8, SLICE=1, add, x=8'h3C, y=8'h05, cin=0, the bench SHALL check: done exactly 8 edges after start is accepted, s=8'h41, c=0, ovf=0, busy high for 8 cycles.
REQ-033 With WIDTH=8, SLICE=4, add, x=8'hFF, y=8'h01, cin=1, the bench SHALL check: done after 2 edges, s=8'h01, c=1, ovf=0.
REQ-034 With WIDTH=8, SLICE=1, add, x=8'h7F, y=8'h01, cin=0, the bench SHALL check: s=8'h80, c=0, ovf=1. With sub, x=8'h80, y=8'h01, it SHALL check: s=8'h7F, c=1, ovf=1.
REQ-035 The bench SHALL hold start high continuously and change x and y every cycle mid-RUN, then check: only the operands latched at E0 are used, and done pulses once per operation back-to-back with no IDLE cycle between operations.
REQ-036 The bench SHALL assert rst asynchronously at cycle 4 of an 8-cycle RUN, then check: all outputs 0 immediately, no done pulse, and a fresh operation afterward completes correctly.
REQ-037 With WIDTH=16, SLICE=8, sub, x=16'h0000, y=16'h0001, the bench SHALL check: s=16'hFFFF, c=0 (borrow), ovf=0.

Source files
------------

// File: rtl/seq_adder.sv
// Bit-serial / slice-serial adder-subtractor: adds SLICE bits per clock, LSB slice first.
// Latency: result and done appear WIDTH/SLICE edges after the edge that accepts start.
// No backpressure: start is ignored while busy; DONE may chain directly into a new RUN.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // Latched operands are shifted right each RUN cycle so the active slice is
  // always in the low SLICE bits; the subtract inversion is applied at latch time.
  logic [WIDTH-1:0] xs_q;
  logic [WIDTH-1:0] ys_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // Partial sums fill acc_q from the top down and only reach s at the last slice.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;

  logic             load;
  logic             last;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;

  assign load      = start && (state_q != RUN);
  assign last      = (cnt_q == CW'(N - 1));
  assign slice_sum = {1'b0, xs_q[SLICE-1:0]} + {1'b0, ys_q[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry_q};
  assign acc_next  = (acc_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));

  assign s   = s_q;
  assign c   = c_q;
  assign ovf = ovf_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; busy and done are mutually exclusive by state
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, per-slice add, and result commit on the final slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q    <= '0;
      ys_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      xs_q    <= x;
      ys_q    <= sub ? ~y : y;
      carry_q <= sub | cin;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else if (state_q == RUN) begin
      xs_q    <= xs_q >> SLICE;
      ys_q    <= ys_q >> SLICE;
      carry_q <= slice_sum[SLICE];
      acc_q   <= acc_next;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        // On the last slice the low slice bits hold the operand MSBs.
        s_q   <= acc_next;
        c_q   <= slice_sum[SLICE];
        ovf_q <= (xs_q[SLICE-1] == ys_q[SLICE-1]) && (slice_sum[SLICE-1] != xs_q[SLICE-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: three instances (8/1, 8/4, 16/8) with per-instance scoreboards.
module tb_seq_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 0, sub0 = 0, cin0 = 0;
  logic [7:0]  x0 = '0, y0 = '0, s0;
  logic        c0, ovf0, busy0, done0;

  logic        start1 = 0, sub1 = 0, cin1 = 0;
  logic [7:0]  x1 = '0, y1 = '0, s1;
  logic        c1, ovf1, busy1, done1;

  logic        start2 = 0, sub2 = 0, cin2 = 0;
  logic [15:0] x2 = '0, y2 = '0, s2;
  logic        c2, ovf2, busy2, done2;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [9:0]  last0 = '0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  seq_adder #(.WIDTH(8), .SLICE(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0), .x(x0), .y(y0), .cin(cin0),
    .s(s0), .c(c0), .ovf(ovf0), .busy(busy0), .done(done0));

  seq_adder #(.WIDTH(8), .SLICE(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .x(x1), .y(y1), .cin(cin1),
    .s(s1), .c(c1), .ovf(ovf1), .busy(busy1), .done(done1));

  seq_adder #(.WIDTH(16), .SLICE(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .x(x2), .y(y2), .cin(cin2),
    .s(s2), .c(c2), .ovf(ovf2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain full-width arithmetic, independent of slicing
  function automatic exp_t model(input int w, input bit sb, input logic [63:0] xv,
                                 input logic [63:0] yv, input bit ci);
    exp_t        r;
    logic [64:0] mask;
    logic [64:0] full;
    logic [63:0] xm, ye;
    mask  = (65'd1 << w) - 65'd1;
    xm    = xv & mask[63:0];
    ye    = (sb ? ~yv : yv) & mask[63:0];
    full  = 65'(xm) + 65'(ye) + 65'(sb | ci);
    r.s   = full[63:0] & mask[63:0];
    r.c   = full[w];
    r.ovf = (xm[w-1] == ye[w-1]) && (r.s[w-1] != xm[w-1]);
    r.due = 0;
    return r;
  endfunction

  function automatic int qsz(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int nslices(input int id);
    return (id == 0) ? 8 : 2;
  endfunction

  // Compare one completion against the head of the instance's queue
  task automatic score(input int id, input logic [63:0] sv, input logic cv, input logic ov);
    exp_t  e;
    string p;
    p = $sformatf("u%0d_", id);
    if (qsz(id) == 0) begin
      check_eq({p, "spurious_done"}, 64'(1), 64'(0));
      return;
    end
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    check_eq({p, "s"}, sv, e.s);
    check_eq({p, "c"}, 64'(cv), 64'(e.c));
    check_eq({p, "ovf"}, 64'(ov), 64'(e.ovf));
    check_eq({p, "done_cycle"}, 64'(cyc), 64'(e.due));
  endtask

  // u0 monitor: results, hold-between-completions, busy/done exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("u0_busy_done_excl", 64'(busy0 & done0), 64'(0));
      if (done0) begin
        if (q0.size() > 0) last0 = {q0[0].c, q0[0].ovf, q0[0].s[7:0]};
        score(0, 64'(s0), c0, ovf0);
      end else begin
        check_eq("u0_result_hold", 64'({c0, ovf0, s0}), 64'(last0));
      end
    end
  end

  always @(negedge clk) if (!rst && done1) score(1, 64'(s1), c1, ovf1);
  always @(negedge clk) if (!rst && done2) score(2, 64'(s2), c2, ovf2);

  // Drive one start pulse (called #1 after an edge) and push the expected result
  task automatic go_exp(input int id, input bit sb, input logic [63:0] xv, input logic [63:0] yv,
                        input bit ci, input logic [63:0] se, input bit ce, input bit oe);
    exp_t e;
    e.s = se; e.c = ce; e.ovf = oe; e.due = cyc + 1 + nslices(id);
    case (id)
      0: begin start0 = 1; sub0 = sb; x0 = xv[7:0];  y0 = yv[7:0];  cin0 = ci; q0.push_back(e); end
      1: begin start1 = 1; sub1 = sb; x1 = xv[7:0];  y1 = yv[7:0];  cin1 = ci; q1.push_back(e); end
      default: begin
         start2 = 1; sub2 = sb; x2 = xv[15:0]; y2 = yv[15:0]; cin2 = ci; q2.push_back(e); end
    endcase
    @(posedge clk); #1;
    start0 = 0; start1 = 0; start2 = 0;
  endtask

  task automatic go(input int id, input bit sb, input logic [63:0] xv, input logic [63:0] yv,
                    input bit ci);
    exp_t m;
    m = model((id == 2) ? 16 : 8, sb, xv, yv, ci);
    go_exp(id, sb, xv, yv, ci, m.s, m.c, m.ovf);
  endtask

  task automatic wait_done(input int id);
    int guard = 0;
    while (qsz(id) != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq($sformatf("u%0d_completion_timeout", id), 64'(qsz(id)), 64'(0));
  endtask

  initial begin
    exp_t m;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_u0_outputs", 64'({s0, c0, ovf0, busy0, done0}), 64'(0));
    check_eq("rst_u1_outputs", 64'({s1, c1, ovf1, busy1, done1}), 64'(0));
    check_eq("rst_u2_outputs", 64'({s2, c2, ovf2, busy2, done2}), 64'(0));
    rst = 0;
    @(posedge clk); #1;

    // 8/1 add: busy for exactly eight cycles, then done
    go_exp(0, 0, 64'h3C, 64'h05, 0, 64'h41, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("u0_busy_during_run", 64'(busy0), 64'(1));
    end
    @(negedge clk);
    check_eq("u0_busy_after_run", 64'(busy0), 64'(0));
    @(posedge clk); #1;
    wait_done(0);

    // Signed overflow both directions
    go_exp(0, 0, 64'h7F, 64'h01, 0, 64'h80, 0, 1);
    wait_done(0);
    go_exp(0, 1, 64'h80, 64'h01, 0, 64'h7F, 1, 1);
    wait_done(0);

    // Wide slices
    go_exp(1, 0, 64'hFF, 64'h01, 1, 64'h01, 1, 0);
    wait_done(1);
    go_exp(2, 1, 64'h0000, 64'h0001, 0, 64'hFFFF, 0, 0);
    wait_done(2);

    // Random operations on every instance
    for (int i = 0; i < 6; i++) begin
      go(0, 1'($urandom), 64'($urandom), 64'($urandom), 1'($urandom));
      wait_done(0);
      go(1, 1'($urandom), 64'($urandom), 64'($urandom), 1'($urandom));
      wait_done(1);
      go(2, 1'($urandom), 64'($urandom), 64'($urandom), 1'($urandom));
      wait_done(2);
    end

    // start held high, operands churn every cycle: only the accepting edge's values count
    start0 = 1;
    for (int op = 0; op < 3; op++) begin
      for (int j = 0; j <= 8; j++) begin
        x0 = 8'($urandom); y0 = 8'($urandom); sub0 = 1'($urandom); cin0 = 1'($urandom);
        if (j == 0) begin
          m = model(8, sub0, 64'(x0), 64'(y0), cin0);
          m.due = cyc + 1 + 8;
          q0.push_back(m);
        end
        @(posedge clk); #1;
      end
    end
    start0 = 0;
    wait_done(0);

    // Asynchronous reset in the middle of a run
    go(0, 0, 64'h12, 64'h34, 0);
    repeat (4) @(posedge clk);
    #4;
    rst = 1;
    q0.delete();
    last0 = '0;
    #1;
    check_eq("midrun_rst_s", 64'(s0), 64'(0));
    check_eq("midrun_rst_flags", 64'({c0, ovf0}), 64'(0));
    check_eq("midrun_rst_busy", 64'(busy0), 64'(0));
    check_eq("midrun_rst_done", 64'(done0), 64'(0));
    @(posedge clk); #1;
    start0 = 1;
    @(posedge clk); #1;
    check_eq("start_ignored_in_rst", 64'({busy0, done0}), 64'(0));
    start0 = 0;
    #2;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    go(0, 1, 64'h05, 64'h09, 1);
    wait_done(0);
    go(0, 0, 64'hA5, 64'h5A, 1);
    wait_done(0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("u0_queue_empty", 64'(q0.size()), 64'(0));
    check_eq("u1_queue_empty", 64'(q1.size()), 64'(0));
    check_eq("u2_queue_empty", 64'(q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
